imem_responder: RTL and testbench

- Instruction-memory responder: the memory end of the fetch handshake (reqValid / respValid) driven by the fetch unit.
- Accepts one fetch request at a time and captures the address.
- After a configurable latency, with optional pseudo-random jitter, returns the word in a single-cycle response.
- Word array is a synchronous-write RAM, loaded by the bench/loader through a write port.

---
 rtl/imem_responder_if.sv | 24 ++
 rtl/imem_responder.sv | 109 ++++++++++
 tb/tb_imem_responder.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_responder_if.sv
// Fetch handshake between a fetch unit (master) and an instruction memory
// responder (slave): one-cycle request strobe with address, one-cycle
// response strobe with word and fault flag, plus a busy indication.
interface imem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              reqValid;
  logic [ADDR_W-1:0] reqAddr;
  logic              respValid;
  logic [DATA_W-1:0] respData;
  logic              respErr;
  logic              busy;

  modport master (
    output reqValid, reqAddr,
    input  respValid, respData, respErr, busy
  );

  modport slave (
    input  reqValid, reqAddr,
    output respValid, respData, respErr, busy
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder. Accepts one fetch at a time, waits a base
// latency plus optional LFSR-driven jitter, then returns the addressed word
// (or an access fault) as a single-cycle response. The word array is loaded
// through a separate synchronous write port that works in every state.
module imem_responder #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 1024,
  parameter int          LAT       = 2,
  parameter int          JITTER_EN = 0,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic              clock,
  input  logic              reset,
  imem_responder_if.slave   bus,
  output logic              protoErr,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [4:0] BASE_CNT = 5'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state;
  logic [4:0]       count;
  logic [7:0]       lfsr;
  logic [7:0]       lfsr_next;
  logic [4:0]       jitter_add;
  logic [4:0]       load_cnt;
  logic [IDX_W-1:0] idx_q;
  logic             fault_q;
  logic             wr_in_range;
  logic             unused_wr_low;

  logic [DATA_W-1:0] mem [DEPTH];

  // A request faults when misaligned or when its word index lies past the array.
  function automatic logic addr_fault(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || (a[ADDR_W-1:IDX_W+2] != '0);
  endfunction

  // Counter load value and the next jitter LFSR value (Galois, taps 0xB8).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    jitter_add = 5'd0;
    if (JITTER_EN != 0) jitter_add = {2'b00, lfsr[2:0]};
    load_cnt  = BASE_CNT + jitter_add;
    lfsr_next = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
  end

  // Request FSM: capture in IDLE, count down in WAIT, strobe the response in RESP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      count    <= 5'd0;
      lfsr     <= LFSR_SEED;
      idx_q    <= '0;
      fault_q  <= 1'b0;
      protoErr <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
      case (state)
        S_IDLE: begin
          if (bus.reqValid) begin
            idx_q   <= bus.reqAddr[IDX_W+1:2];
            fault_q <= addr_fault(bus.reqAddr);
            count   <= load_cnt;
            lfsr    <= lfsr_next;
            state   <= (load_cnt != 5'd0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          count <= count - 5'd1;
          if (count == 5'd1) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // A request while a fetch is in flight is dropped but remembered until reset.
      if (bus.reqValid && (state != S_IDLE)) protoErr <= 1'b1;
    end
  end

  // Loader writes: one word per cycle, out-of-range addresses are discarded.
  assign wr_in_range   = (wrAddr[ADDR_W-1:IDX_W+2] == '0);
  assign unused_wr_low = ^wrAddr[1:0];

  // Word array write port.
  always_ff @(posedge clock) begin
    // NOTE: the array has no reset; its contents survive reset and are only changed by the loader.
    if (wrEn && wr_in_range) mem[wrAddr[IDX_W+1:2]] <= wrData;
  end

  // Response outputs decode the registered state; data and fault are zero outside RESP.
  // NOTE: the array is read combinationally in RESP, so a same-cycle write to that word
  // returns the old contents and commits at the closing edge.
  assign bus.respValid = (state == S_RESP);
  assign bus.respErr   = (state == S_RESP) && fault_q;
  assign bus.respData  = ((state == S_RESP) && !fault_q) ? mem[idx_q] : '0;
  assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder. Three instances share the loader
// port: LAT=2 without jitter (a), LAT=1 without jitter (b) and LAT=2 with
// jitter (c). Expected responses go into a scoreboard queue when a request is
// driven; a monitor queues every observed response and the tasks compare them.
module tb_imem_responder;

  typedef struct {
    int          dut;
    int          cyc;
    logic [31:0] data;
    logic        err;
  } resp_t;

  logic        clock;
  logic        reset;
  logic        wrEn;
  logic [31:0] wrAddr;
  logic [31:0] wrData;
  logic        protoErr_a, protoErr_b, protoErr_c;

  int          cyc = 0;
  int          junk = 0;
  int          checks = 0;
  int          errors = 0;
  resp_t       exp_q[$];
  resp_t       obs_q[$];
  logic [31:0] model_mem [8];
  logic [7:0]  jit_lfsr = 8'hA5;

  imem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  imem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();
  imem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus_c ();

  imem_responder #(.LAT(2), .JITTER_EN(0)) u_a (
    .clock(clock), .reset(reset), .bus(bus_a), .protoErr(protoErr_a),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData)
  );
  imem_responder #(.LAT(1), .JITTER_EN(0)) u_b (
    .clock(clock), .reset(reset), .bus(bus_b), .protoErr(protoErr_b),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData)
  );
  imem_responder #(.LAT(2), .JITTER_EN(1), .LFSR_SEED(8'hA5)) u_c (
    .clock(clock), .reset(reset), .bus(bus_c), .protoErr(protoErr_c),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // NOTE: outputs are sampled on the falling edge, half a cycle away from the active edge.
  always @(negedge clock) begin
    if (bus_a.respValid) obs_q.push_back('{0, cyc, bus_a.respData, bus_a.respErr});
    else if (bus_a.respData !== 32'd0 || bus_a.respErr !== 1'b0) junk <= junk + 1;
    if (bus_b.respValid) obs_q.push_back('{1, cyc, bus_b.respData, bus_b.respErr});
    else if (bus_b.respData !== 32'd0 || bus_b.respErr !== 1'b0) junk <= junk + 1;
    if (bus_c.respValid) obs_q.push_back('{2, cyc, bus_c.respData, bus_c.respErr});
    else if (bus_c.respData !== 32'd0 || bus_c.respErr !== 1'b0) junk <= junk + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive a one-cycle request on instance d from the current falling edge; t is the request cycle.
  task automatic issue(input int d, input logic [31:0] a, output int t);
    t = cyc;
    case (d)
      0:       begin bus_a.reqValid = 1'b1; bus_a.reqAddr = a; end
      1:       begin bus_b.reqValid = 1'b1; bus_b.reqAddr = a; end
      default: begin bus_c.reqValid = 1'b1; bus_c.reqAddr = a; end
    endcase
    @(negedge clock);
    bus_a.reqValid = 1'b0;
    bus_b.reqValid = 1'b0;
    bus_c.reqValid = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    wrEn = 1'b1; wrAddr = a; wrData = d;
    @(negedge clock);
    wrEn = 1'b0;
  endtask

  // Pop every expected response and compare it with the next observed one.
  task automatic sb_compare(input string name, input int budget);
    resp_t e, o;
    int    waited;
    #1;
    while (exp_q.size() != 0) begin
      waited = 0;
      while (obs_q.size() == 0 && waited < budget) begin
        @(negedge clock); #1;
        waited++;
      end
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s: no response within %0d cycles, wanted dut %0d at cycle %0d",
                 name, budget, e.dut, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.dut !== e.dut || o.cyc !== e.cyc) begin
          errors++;
          $display("FAIL %s timing: got dut %0d cycle %0d, wanted dut %0d cycle %0d",
                   name, o.dut, o.cyc, e.dut, e.cyc);
        end
        checks++;
        if (o.data !== e.data || o.err !== e.err) begin
          errors++;
          $display("FAIL %s data: got %h err %b, wanted %h err %b",
                   name, o.data, o.err, e.data, e.err);
        end
      end
    end
  endtask

  // A few idle cycles must show no extra strobes and no data/err outside respValid.
  task automatic idle_tail(input string name);
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (obs_q.size() != 0 || junk != 0) begin
      errors++;
      $display("FAIL %s idle: got %0d stray responses and %0d dirty idle samples, wanted 0 and 0",
               name, obs_q.size(), junk);
    end
    obs_q.delete();
    junk = 0;
  endtask

  task automatic test_reset();
    logic [35:0] got;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    got = {bus_a.respValid, bus_a.respErr, bus_a.busy, protoErr_a, bus_a.respData};
    checks++;
    if (got !== 36'd0) begin
      errors++;
      $display("FAIL reset_hold_a: got %h, wanted 0", got);
    end
    reset = 1'b1;
    #1;
    got = {bus_b.respValid, bus_b.respErr, bus_b.busy, protoErr_b, bus_b.respData};
    checks++;
    if (got !== 36'd0) begin
      errors++;
      $display("FAIL reset_release_b: got %h, wanted 0", got);
    end
    got = {bus_c.respValid, bus_c.respErr, bus_c.busy, protoErr_c, bus_c.respData};
    checks++;
    if (got !== 36'd0) begin
      errors++;
      $display("FAIL reset_release_c: got %h, wanted 0", got);
    end
    repeat (10) @(negedge clock);
    idle_tail("reset_idle");
  endtask

  task automatic load_mem();
    logic [31:0] v;
    for (int k = 0; k < 8; k++) begin
      case (k)
        0:       v = 32'h0000_0013;
        1:       v = 32'h0010_0113;
        4:       v = 32'h0050_0093;
        default: v = 32'h0A00_0000 | 32'(k);
      endcase
      load_word(32'(k * 4), v);
      model_mem[k] = v;
    end
  endtask

  task automatic test_basic();
    int t;
    @(negedge clock);
    checks++;
    if (bus_a.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_t: got %b, wanted 0", bus_a.busy);
    end
    issue(0, 32'h10, t);
    exp_q.push_back('{0, t + 2, model_mem[4], 1'b0});
    checks++;
    if (bus_a.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_t1: got %b, wanted 1", bus_a.busy);
    end
    @(negedge clock);
    checks++;
    if (bus_a.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_t2: got %b, wanted 1", bus_a.busy);
    end
    @(negedge clock);
    checks++;
    if (bus_a.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_t3: got %b, wanted 0", bus_a.busy);
    end
    sb_compare("basic", 20);
    idle_tail("basic");
  endtask

  task automatic test_read_before_write();
    int t;
    @(negedge clock);
    issue(0, 32'h8, t);
    exp_q.push_back('{0, t + 2, model_mem[2], 1'b0});
    @(negedge clock);
    wrEn = 1'b1; wrAddr = 32'h8; wrData = 32'hCAFE_0002;
    @(negedge clock);
    wrEn = 1'b0;
    model_mem[2] = 32'hCAFE_0002;
    sb_compare("rbw_old", 20);
    @(negedge clock);
    issue(0, 32'h8, t);
    exp_q.push_back('{0, t + 2, model_mem[2], 1'b0});
    sb_compare("rbw_new", 20);
    idle_tail("rbw");
  endtask

  task automatic test_back_to_back();
    int t;
    @(negedge clock);
    issue(1, 32'h0, t);
    exp_q.push_back('{1, t + 1, model_mem[0], 1'b0});
    sb_compare("b2b_first", 10);
    @(negedge clock);
    issue(1, 32'h4, t);
    exp_q.push_back('{1, t + 1, model_mem[1], 1'b0});
    sb_compare("b2b_second", 10);
    idle_tail("b2b");
  endtask

  task automatic test_faults();
    int t;
    @(negedge clock);
    issue(0, 32'h6, t);
    exp_q.push_back('{0, t + 2, 32'd0, 1'b1});
    sb_compare("fault_misaligned", 20);
    @(negedge clock);
    issue(0, 32'h1000, t);
    exp_q.push_back('{0, t + 2, 32'd0, 1'b1});
    sb_compare("fault_depth", 20);
    @(negedge clock);
    issue(0, 32'hFFFF_FFFC, t);
    exp_q.push_back('{0, t + 2, 32'd0, 1'b1});
    sb_compare("fault_high", 20);
    load_word(32'hFFC, 32'h0FFC_0FFC);
    load_word(32'h1000, 32'hBAD0_BAD0);
    @(negedge clock);
    issue(0, 32'hFFC, t);
    exp_q.push_back('{0, t + 2, 32'h0FFC_0FFC, 1'b0});
    sb_compare("last_word", 20);
    @(negedge clock);
    issue(0, 32'h0, t);
    exp_q.push_back('{0, t + 2, model_mem[0], 1'b0});
    sb_compare("oob_write_dropped", 20);
    checks++;
    if (protoErr_a !== 1'b0) begin
      errors++;
      $display("FAIL fault_proto: got %b, wanted 0", protoErr_a);
    end
    idle_tail("faults");
  endtask

  task automatic test_proto_err();
    int t, t2;
    @(negedge clock);
    issue(0, 32'h10, t);
    exp_q.push_back('{0, t + 2, model_mem[4], 1'b0});
    issue(0, 32'h0, t2);
    sb_compare("proto_inflight", 20);
    checks++;
    if (protoErr_a !== 1'b1) begin
      errors++;
      $display("FAIL proto_set: got %b, wanted 1", protoErr_a);
    end
    repeat (5) @(negedge clock);
    checks++;
    if (protoErr_a !== 1'b1) begin
      errors++;
      $display("FAIL proto_sticky: got %b, wanted 1", protoErr_a);
    end
    idle_tail("proto");
  endtask

  task automatic test_jitter();
    int t;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      issue(2, 32'(i * 4), t);
      exp_q.push_back('{2, t + 2 + int'(jit_lfsr[2:0]), model_mem[i], 1'b0});
      jit_lfsr = {1'b0, jit_lfsr[7:1]} ^ (jit_lfsr[0] ? 8'hB8 : 8'h00);
      sb_compare("jitter", 40);
    end
    idle_tail("jitter");
  endtask

  task automatic test_reset_mid();
    int t;
    @(negedge clock);
    issue(2, 32'h10, t);
    reset = 1'b0;
    #1;
    checks++;
    if (bus_c.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_busy: got %b, wanted 0", bus_c.busy);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (30) @(negedge clock);
    #1;
    checks++;
    if (bus_c.busy !== 1'b0 || protoErr_a !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_after: got busy %b protoErr_a %b, wanted 0 0",
               bus_c.busy, protoErr_a);
    end
    idle_tail("mid_reset_abort");
    jit_lfsr = 8'hA5;
    @(negedge clock);
    issue(2, 32'h10, t);
    exp_q.push_back('{2, t + 2 + int'(jit_lfsr[2:0]), model_mem[4], 1'b0});
    sb_compare("mid_reset_seed", 40);
    idle_tail("mid_reset_seed");
  endtask

  initial begin
    bus_a.reqValid = 1'b0; bus_a.reqAddr = 32'd0;
    bus_b.reqValid = 1'b0; bus_b.reqAddr = 32'd0;
    bus_c.reqValid = 1'b0; bus_c.reqAddr = 32'd0;
    wrEn = 1'b0; wrAddr = 32'd0; wrData = 32'd0;
    reset = 1'b0;
    test_reset();
    load_mem();
    test_basic();
    test_read_before_write();
    test_back_to_back();
    test_faults();
    test_proto_err();
    test_jitter();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
